// File: rtl/instr_stream_loader.sv
// Byte-stream loader: packs bytes MSB-first into 32-bit words, strobes each word
// into instruction memory, and holds the CPU in reset until the program is loaded.
module instr_stream_loader #(
  parameter int unsigned MAX_WORDS  = 32,
  parameter int unsigned CNT_W      = 6,
  parameter int unsigned RESET_HOLD = 4
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             start,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  output logic             byte_ready,
  input  logic             byte_last,
  output logic [31:0]      Instruction,
  output logic             LoadInstructions,
  output logic             cpu_reset,
  output logic [CNT_W-1:0] word_count,
  output logic             busy,
  output logic             done,
  output logic             overflow
);

  localparam int unsigned HW = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_WRITE,
    S_HOLD,
    S_RUN
  } state_t;

  state_t           state_q;
  logic [1:0]       idx_q;
  logic [23:0]      sh_q;
  logic             last_q;
  logic [HW-1:0]    hold_q;
  logic             byte_ready_q;
  logic [31:0]      instr_q;
  logic             load_q;
  logic             cpu_reset_q;
  logic [CNT_W-1:0] word_count_q;
  logic             busy_q;
  logic             done_q;
  logic             overflow_q;

  logic             accept_d;
  logic [4:0]       shamt_d;
  logic [31:0]      packed_d;

  // Earlier bytes of the word live in sh_q; left-justify by the unfilled byte count.
  always_comb begin
    accept_d = '0;
    shamt_d  = '0;
    packed_d = '0;
    accept_d = (state_q == S_RECV) && byte_valid && byte_ready_q;
    shamt_d  = {~idx_q, 3'b000};
    packed_d = {sh_q, byte_in} << shamt_d;
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      sh_q         <= '0;
      last_q       <= 1'b0;
      hold_q       <= '0;
      byte_ready_q <= 1'b0;
      instr_q      <= '0;
      load_q       <= 1'b0;
      cpu_reset_q  <= 1'b1;
      word_count_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_RUN: begin
          if (start) begin
            state_q      <= S_RECV;
            byte_ready_q <= 1'b1;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            cpu_reset_q  <= 1'b1;
            word_count_q <= '0;
            overflow_q   <= 1'b0;
            idx_q        <= '0;
            last_q       <= 1'b0;
          end
        end
        S_RECV: begin
          if (accept_d) begin
            sh_q  <= {sh_q[15:0], byte_in};
            idx_q <= idx_q + 2'd1;
            if (idx_q == 2'd3 || byte_last) begin
              state_q      <= S_WRITE;
              byte_ready_q <= 1'b0;
              load_q       <= 1'b1;
              instr_q      <= packed_d;
              word_count_q <= word_count_q + CNT_W'(1);
              last_q       <= byte_last;
            end
          end
        end
        S_WRITE: begin
          load_q <= 1'b0;
          idx_q  <= '0;
          if (last_q || word_count_q == CNT_W'(MAX_WORDS)) begin
            state_q <= S_HOLD;
            hold_q  <= HW'(RESET_HOLD - 1);
            if (!last_q) overflow_q <= 1'b1;
          end else begin
            state_q      <= S_RECV;
            byte_ready_q <= 1'b1;
          end
        end
        S_HOLD: begin
          if (hold_q == '0) begin
            state_q     <= S_RUN;
            cpu_reset_q <= 1'b0;
            done_q      <= 1'b1;
            busy_q      <= 1'b0;
          end else begin
            hold_q <= hold_q - HW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign byte_ready       = byte_ready_q;
  assign Instruction      = instr_q;
  assign LoadInstructions = load_q;
  assign cpu_reset        = cpu_reset_q;
  assign word_count       = word_count_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign overflow         = overflow_q;

endmodule

// File: tb/tb_instr_stream_loader.sv
// Directed bench for instr_stream_loader with a two-word memory so the
// capacity limit is reachable; expected values are hand-computed.
module tb_instr_stream_loader;

  logic        clk = 1'b0;
  logic        Reset;
  logic        start;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        byte_last;
  logic [31:0] Instruction;
  logic        LoadInstructions;
  logic        cpu_reset;
  logic [5:0]  word_count;
  logic        busy;
  logic        done;
  logic        overflow;

  int vec_cnt = 0;
  int err_cnt = 0;
  int strobes = 0;

  instr_stream_loader #(
    .MAX_WORDS (2),
    .CNT_W     (6),
    .RESET_HOLD(4)
  ) dut (
    .clk             (clk),
    .Reset           (Reset),
    .start           (start),
    .byte_in         (byte_in),
    .byte_valid      (byte_valid),
    .byte_ready      (byte_ready),
    .byte_last       (byte_last),
    .Instruction     (Instruction),
    .LoadInstructions(LoadInstructions),
    .cpu_reset       (cpu_reset),
    .word_count      (word_count),
    .busy            (busy),
    .done            (done),
    .overflow        (overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (LoadInstructions) strobes++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // Returns just after the accepting edge; gap = idle cycles before valid.
  task automatic send_byte(input logic [7:0] b, input logic last, input int gap);
    int n;
    repeat (gap) @(negedge clk);
    byte_in = b; byte_valid = 1'b1; byte_last = last;
    n = 0;
    while (!byte_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 byte_valid = 1'b0; byte_last = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("done_wait", {31'd0, done}, 32'd1);
  endtask

  initial begin
    int s0;
    Reset = 1'b1; start = 1'b0; byte_in = '0; byte_valid = 1'b0; byte_last = 1'b0;
    #1;
    chk("rst_ready", {31'd0, byte_ready}, 32'd0);
    chk("rst_cpurst", {31'd0, cpu_reset}, 32'd1);
    chk("rst_instr", Instruction, 32'd0);
    chk("rst_flags", {27'd0, LoadInstructions, busy, done, overflow, 1'b0}, 32'd0);
    chk("rst_wc", {26'd0, word_count}, 32'd0);
    repeat (2) @(negedge clk);
    Reset = 1'b0;
    @(negedge clk);
    chk("idle_ready", {31'd0, byte_ready}, 32'd0);

    // 1: single word, last on 4th byte, then reset-hold countdown
    pulse_start();
    chk("t1_busy", {31'd0, busy}, 32'd1);
    s0 = strobes;
    send_byte(8'h20, 1'b0, 0);
    send_byte(8'h01, 1'b0, 0);
    send_byte(8'h00, 1'b0, 0);
    send_byte(8'h05, 1'b1, 0);
    @(negedge clk);
    chk("t1_strobe", {31'd0, LoadInstructions}, 32'd1);
    chk("t1_instr", Instruction, 32'h20010005);
    chk("t1_wc", {26'd0, word_count}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t1_hold_cpurst", {31'd0, cpu_reset}, 32'd1);
    end
    @(negedge clk);
    chk("t1_run_cpurst", {31'd0, cpu_reset}, 32'd0);
    chk("t1_done", {31'd0, done}, 32'd1);
    chk("t1_nstrobes", strobes - s0, 32'd1);

    // 2: restart from RUN with idle gaps between bytes
    pulse_start();
    chk("t2_cpurst", {31'd0, cpu_reset}, 32'd1);
    chk("t2_wc_clr", {26'd0, word_count}, 32'd0);
    s0 = strobes;
    send_byte(8'h20, 1'b0, 1);
    send_byte(8'h01, 1'b0, 3);
    send_byte(8'h00, 1'b0, 2);
    send_byte(8'h05, 1'b1, 1);
    @(negedge clk);
    chk("t2_strobe", {31'd0, LoadInstructions}, 32'd1);
    chk("t2_instr", Instruction, 32'h20010005);
    @(negedge clk);
    chk("t2_strobe_off", {31'd0, LoadInstructions}, 32'd0);
    wait_done();
    chk("t2_nstrobes", strobes - s0, 32'd1);

    // 3: short final word, low bytes zero-filled
    pulse_start();
    send_byte(8'hAB, 1'b0, 0);
    send_byte(8'hCD, 1'b1, 0);
    @(negedge clk);
    chk("t3_instr", Instruction, 32'hABCD0000);
    chk("t3_wc", {26'd0, word_count}, 32'd1);
    wait_done();
    chk("t3_ovf", {31'd0, overflow}, 32'd0);

    // 4: capacity reached without byte_last
    pulse_start();
    s0 = strobes;
    for (int i = 1; i <= 8; i++) begin
      send_byte(8'(i), 1'b0, 0);
      if (i == 4) begin
        @(negedge clk);
        chk("t4_w0", Instruction, 32'h01020304);
      end
    end
    @(negedge clk);
    chk("t4_w1", Instruction, 32'h05060708);
    chk("t4_ready_off", {31'd0, byte_ready}, 32'd0);
    byte_in = 8'h09; byte_valid = 1'b1;
    wait_done();
    repeat (3) @(negedge clk);
    chk("t4_ready_run", {31'd0, byte_ready}, 32'd0);
    chk("t4_ovf", {31'd0, overflow}, 32'd1);
    chk("t4_wc", {26'd0, word_count}, 32'd2);
    chk("t4_nstrobes", strobes - s0, 32'd2);
    byte_valid = 1'b0;

    // 5: asynchronous reset mid-word
    pulse_start();
    s0 = strobes;
    send_byte(8'h11, 1'b0, 0);
    send_byte(8'h22, 1'b0, 0);
    #2 Reset = 1'b1;
    #1;
    chk("t5_ready", {31'd0, byte_ready}, 32'd0);
    chk("t5_cpurst", {31'd0, cpu_reset}, 32'd1);
    chk("t5_busy", {31'd0, busy}, 32'd0);
    chk("t5_wc", {26'd0, word_count}, 32'd0);
    chk("t5_instr", Instruction, 32'd0);
    @(negedge clk) Reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("t5_nostrobe", strobes - s0, 32'd0);

    // 6: start ignored while receiving
    pulse_start();
    send_byte(8'hDE, 1'b0, 0);
    pulse_start();
    send_byte(8'hAD, 1'b0, 0);
    send_byte(8'hBE, 1'b0, 0);
    send_byte(8'hEF, 1'b1, 0);
    @(negedge clk);
    chk("t6_instr", Instruction, 32'hDEADBEEF);
    chk("t6_wc", {26'd0, word_count}, 32'd1);
    wait_done();
    pulse_start();
    chk("t6_run_cpurst", {31'd0, cpu_reset}, 32'd1);
    chk("t6_run_done", {31'd0, done}, 32'd0);
    send_byte(8'h7F, 1'b1, 0);
    @(negedge clk);
    chk("t6_reload", Instruction, 32'h7F000000);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

endmodule
